// File: rtl/barrelshift_arbiter.sv
// Two-requester round-robin front end sharing one rotate-right barrel shifter.
// Optional macro BARSHIFT_ARB_STATS_EN adds saturating 16-bit grant counters.

module barrelshifter #(
  parameter int N = 3
) (
  input  logic [2**N-1:0] a,
  input  logic [N-1:0]    amt,
  output logic [2**N-1:0] y
);
  localparam int W = 2**N;

  // Shifting a doubled copy right makes the low bits wrap into the top.
  logic [2*W-1:0] w_dbl;

  assign w_dbl = {a, a} >> amt;
  assign y     = w_dbl[W-1:0];
endmodule

// state | meaning
// IDLE  | arbitrate, accept one request into the operand registers
// SHIFT | shifter output registered into the result
// HOLD  | result presented until the consumer takes it
module barrelshift_arbiter #(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [2**N-1:0] req0_data,
  input  logic [N-1:0]   req0_amt,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [2**N-1:0] req1_data,
  input  logic [N-1:0]   req1_amt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2**N-1:0] out_data,
  output logic           out_src
`ifdef BARSHIFT_ARB_STATS_EN
  ,
  output logic [15:0]    grant_cnt0,
  output logic [15:0]    grant_cnt1
`endif
);
  localparam int W = 2**N;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]   r_state;
  logic [W-1:0] r_op_data;
  logic [N-1:0] r_op_amt;
  logic         r_src;
  logic         r_last_grant;
  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_out_src;

  logic         w_gnt_valid;
  logic         w_gnt_idx;
  logic         w_accept;
  logic [W-1:0] w_shift_y;

  // Under contention the requester that did not win last time gets the grant.
  always_comb begin
    w_gnt_valid = req0_valid | req1_valid;
    w_gnt_idx   = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt_idx = ~r_last_grant;
    end else begin
      w_gnt_idx = req1_valid;
    end
  end

  assign w_accept   = (r_state == IDLE) & w_gnt_valid;
  assign req0_ready = w_accept & ~w_gnt_idx & req0_valid;
  assign req1_ready = w_accept &  w_gnt_idx & req1_valid;

  barrelshifter #(.N(N)) u_shifter (
    .a   (r_op_data),
    .amt (r_op_amt),
    .y   (w_shift_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_op_data    <= '0;
      r_op_amt     <= '0;
      r_src        <= 1'b0;
      r_last_grant <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_src    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op_data    <= w_gnt_idx ? req1_data : req0_data;
            r_op_amt     <= w_gnt_idx ? req1_amt  : req0_amt;
            r_src        <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            r_state      <= SHIFT;
          end
        end
        SHIFT: begin
          r_out_data  <= w_shift_y;
          r_out_src   <= r_src;
          r_out_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

`ifdef BARSHIFT_ARB_STATS_EN
  logic [15:0] r_grant_cnt0;
  logic [15:0] r_grant_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
    end else begin
      if (req0_ready && (r_grant_cnt0 != 16'hFFFF)) r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      if (req1_ready && (r_grant_cnt1 != 16'hFFFF)) r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`endif
endmodule

// File: tb/tb_barrelshift_arbiter.sv
// Directed bench for barrelshift_arbiter with an expected-result queue.
module tb_barrelshift_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_data;
  logic [2:0] req0_amt;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_data;
  logic [2:0] req1_amt;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_src;
`ifdef BARSHIFT_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;
  int n0 = 0;
  int n1 = 0;
  logic [8:0] q[$];

  barrelshift_arbiter #(.N(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src)
`ifdef BARSHIFT_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ror8(input logic [7:0] d, input logic [2:0] a);
    logic [7:0] r;
    r = d;
    for (int i = 0; i < int'(a); i++) r = {r[0], r[7:1]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int src, input string tag);
    int n;
    n = 0;
    #1;
    while (!(src != 0 ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, " ready_timeout"}, 32'(n >= 20), 0);
  endtask

  task automatic push_exp(input int src, input logic [7:0] d, input logic [2:0] a);
    q.push_back({src[0], ror8(d, a)});
    if (src != 0) n1++; else n0++;
  endtask

  // Returns at the negedge of the SHIFT cycle.
  task automatic issue(input int src, input logic [7:0] d, input logic [2:0] a, input string tag);
    if (src != 0) begin
      req1_valid = 1'b1; req1_data = d; req1_amt = a;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_amt = a;
    end
    wait_ready(src, tag);
    push_exp(src, d, a);
    @(negedge clk);
    if (src != 0) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Returns at the negedge after the output handshake.
  task automatic collect(input string tag);
    int n;
    logic [8:0] e;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " out_timeout"}, 32'(n >= 20), 0);
    chk({tag, " queue_size"}, 32'(q.size() > 0), 1);
    e = (q.size() > 0) ? q.pop_front() : 9'h0;
    chk({tag, " data"}, {24'h0, out_data}, {24'h0, e[7:0]});
    chk({tag, " src"}, {31'h0, out_src}, {31'h0, e[8]});
    @(negedge clk);
  endtask

  initial begin
    int res;
    logic [2:0] amts [3];
    logic [8:0] e;
    amts[0] = 3'd0; amts[1] = 3'd3; amts[2] = 3'd7;
    rst_n = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_amt = '0;
    req1_valid = 1'b0; req1_data = '0; req1_amt = '0;
    @(negedge clk); @(negedge clk);
    chk("rst out_valid", {31'h0, out_valid}, 0);
    chk("rst out_data", {24'h0, out_data}, 0);
    chk("rst out_src", {31'h0, out_src}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single request with latency check
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'b00010001; req0_amt = 3'd1;
    wait_ready(0, "single");
    push_exp(0, 8'b00010001, 3'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("single lat_shift", {31'h0, out_valid}, 0);
    @(negedge clk);
    chk("single lat_hold", {31'h0, out_valid}, 1);
    chk("single literal", {24'h0, out_data}, 32'h88);
    collect("single");
    chk("single after_hs", {31'h0, out_valid}, 0);

    foreach (amts[i]) begin
      issue(1, 8'b00010001, amts[i], "sweep");
      collect("sweep");
    end

    // contention
    req0_valid = 1'b1; req0_data = 8'h11; req0_amt = 3'd1;
    req1_valid = 1'b1; req1_data = 8'h80; req1_amt = 3'd7;
    #1;
    chk("cont r0_ready", {31'h0, req0_ready}, 1);
    chk("cont r1_ready", {31'h0, req1_ready}, 0);
    push_exp(0, 8'h11, 3'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1 chk("cont r1_ready_shift", {31'h0, req1_ready}, 0);
    @(negedge clk);
    #1 chk("cont r1_ready_hold", {31'h0, req1_ready}, 0);
    collect("cont first");
    #1 chk("cont r1_ready_idle", {31'h0, req1_ready}, 1);
    push_exp(1, 8'h80, 3'd7);
    @(negedge clk);
    req1_valid = 1'b0;
    collect("cont second");

    // back-pressure
    out_ready = 1'b0;
    issue(0, 8'hA5, 3'd4, "bp");
    req1_valid = 1'b1; req1_data = 8'h3C; req1_amt = 3'd2;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp valid", {31'h0, out_valid}, 1);
      chk("bp data", {24'h0, out_data}, 32'h5A);
      chk("bp src", {31'h0, out_src}, 0);
      chk("bp r0_ready", {31'h0, req0_ready}, 0);
      chk("bp r1_ready", {31'h0, req1_ready}, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    collect("bp result");
    #1;
    chk("bp idle out_valid", {31'h0, out_valid}, 0);
    chk("bp idle r1_ready", {31'h0, req1_ready}, 1);
    push_exp(1, 8'h3C, 3'd2);
    @(negedge clk);
    req1_valid = 1'b0;
    collect("bp follow");

    // reset in SHIFT, then in HOLD
    issue(0, 8'h42, 3'd1, "rst_shift");
    rst_n = 1'b0;
    #1 chk("rst_shift out_valid", {31'h0, out_valid}, 0);
    q.delete(); n0 = 0; n1 = 0;
    @(negedge clk);
    chk("rst_shift held", {31'h0, out_valid}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 8'h42, 3'd1, "rst_hold");
    @(negedge clk);
    chk("rst_hold pre", {31'h0, out_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_hold out_valid", {31'h0, out_valid}, 0);
    chk("rst_hold out_data", {24'h0, out_data}, 0);
    q.delete(); n0 = 0; n1 = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // continuous contention after reset: 0,1,0,1
    req0_valid = 1'b1; req0_data = 8'h11; req0_amt = 3'd1;
    req1_valid = 1'b1; req1_data = 8'h80; req1_amt = 3'd7;
    res = 0;
    for (int c = 0; c < 40 && res < 4; c++) begin
      #1;
      if (req0_ready) push_exp(0, 8'h11, 3'd1);
      if (req1_ready) push_exp(1, 8'h80, 3'd7);
      if (out_valid) begin
        chk("b2b queue_size", 32'(q.size() > 0), 1);
        e = (q.size() > 0) ? q.pop_front() : 9'h0;
        chk("b2b data", {24'h0, out_data}, {24'h0, e[7:0]});
        chk("b2b order", {31'h0, out_src}, 32'(res % 2));
        res++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("b2b count", 32'(res), 4);

`ifdef BARSHIFT_ARB_STATS_EN
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("stats cnt0", {16'h0, grant_cnt0}, 32'(n0));
    chk("stats cnt1", {16'h0, grant_cnt1}, 32'(n1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
